// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the pc, issues word addresses to a registered-output
// instruction memory and tracks which fetched word is valid, squashed or held.
module fetch_unit #(
    parameter logic [15:0] RESET_ADDR = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        halt,
    input  logic        resume,
    output logic [15:0] outAddy,
    output logic [15:0] pc_plus1,
    output logic [15:0] ir_pc,
    output logic        fetch_valid,
    output logic [1:0]  state,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } fetch_state_e;

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  ir_pc_q, ir_pc_d;
    logic         valid_q, valid_d;
    logic [31:0]  count_q, count_d;

    logic [15:0]  pc_inc;
    logic [15:0]  branch_target;
    logic         unused_jump_hi;

    assign pc_inc = pc_q + 16'd1;
    // A 16-bit add of the raw offset is the same as sign-extend then truncate.
    assign branch_target = pc_inc + branch_offset;
    assign unused_jump_hi = ^jump_target[25:16];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_pc_d = ir_pc_q;
        valid_d = valid_q;
        count_d = count_q;
        unique case (state_q)
            StBoot: begin
                pc_d    = RESET_ADDR;
                valid_d = 1'b0;
                state_d = halt ? StHalt : StRun;
            end
            StRun: begin
                if (halt) begin
                    state_d = StHalt;
                    valid_d = 1'b0;
                end else if (jump) begin
                    // Redirects win over stall; the word in flight is from the wrong path.
                    pc_d    = jump_target[15:0];
                    ir_pc_d = pc_q;
                    valid_d = 1'b0;
                end else if (branch_taken) begin
                    pc_d    = branch_target;
                    ir_pc_d = pc_q;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    pc_d    = pc_inc;
                    ir_pc_d = pc_q;
                    valid_d = 1'b1;
                    count_d = count_q + 32'd1;
                end
            end
            StHalt: begin
                valid_d = 1'b0;
                if (resume && !halt) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StBoot;
                pc_d    = RESET_ADDR;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StBoot;
            pc_q    <= RESET_ADDR;
            ir_pc_q <= RESET_ADDR;
            valid_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_pc_q <= ir_pc_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign outAddy     = pc_q;
    assign pc_plus1    = pc_inc;
    assign ir_pc       = ir_pc_q;
    assign fetch_valid = valid_q;
    assign state       = state_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the driver queues hand-computed post-edge outputs, a monitor
// pops and compares them one time unit after each rising edge.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_offset = 16'h0;
    logic        jump = 1'b0;
    logic [25:0] jump_target = 26'h0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic [15:0] outAddy, pc_plus1, ir_pc;
    logic        fetch_valid;
    logic [1:0]  state;
    logic [31:0] fetch_count;

    fetch_unit #(.RESET_ADDR(16'h0000)) dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_target  (jump_target),
        .halt         (halt),
        .resume       (resume),
        .outAddy      (outAddy),
        .pc_plus1     (pc_plus1),
        .ir_pc        (ir_pc),
        .fetch_valid  (fetch_valid),
        .state        (state),
        .fetch_count  (fetch_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          step;
        logic [15:0] addr;
        logic [15:0] pp;
        logic [15:0] ir;
        logic        fv;
        logic [1:0]  st;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_failed = 0;
    int   step_no = 0;

    task automatic chk(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, step, act, exp);
        end
    endtask

    task automatic chk_reset(input int step);
        chk("reset outAddy", step, {16'h0, outAddy}, 32'h0);
        chk("reset ir_pc", step, {16'h0, ir_pc}, 32'h0);
        chk("reset fetch_valid", step, {31'h0, fetch_valid}, 32'h0);
        chk("reset state", step, {30'h0, state}, 32'h0);
        chk("reset fetch_count", step, fetch_count, 32'h0);
    endtask

    // Called at a falling edge: drive inputs for the next rising edge and queue its outcome.
    task automatic cyc(input logic s, input logic b, input logic [15:0] off, input logic j,
                       input logic [25:0] jt, input logic h, input logic r,
                       input logic [15:0] ea, input logic [15:0] ei, input logic ev,
                       input logic [1:0] es, input logic [31:0] ec);
        exp_t e;
        stall = s; branch_taken = b; branch_offset = off;
        jump = j; jump_target = jt; halt = h; resume = r;
        step_no++;
        e.step = step_no;
        e.addr = ea;
        e.pp   = ea + 16'd1;
        e.ir   = ei;
        e.fv   = ev;
        e.st   = es;
        e.cnt  = ec;
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    task automatic idle(input logic [15:0] ea, input logic [15:0] ei, input logic ev,
                        input logic [1:0] es, input logic [31:0] ec);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 1'b0, ea, ei, ev, es, ec);
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("outAddy", e.step, {16'h0, outAddy}, {16'h0, e.addr});
            chk("pc_plus1", e.step, {16'h0, pc_plus1}, {16'h0, e.pp});
            chk("ir_pc", e.step, {16'h0, ir_pc}, {16'h0, e.ir});
            chk("fetch_valid", e.step, {31'h0, fetch_valid}, {31'h0, e.fv});
            chk("state", e.step, {30'h0, state}, {30'h0, e.st});
            chk("fetch_count", e.step, fetch_count, e.cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset holds without any clock edge yet.
        #1;
        chk_reset(0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk_reset(0);

        // Free run out of BOOT.
        idle(16'h0000, 16'h0000, 1'b0, 2'd1, 0);
        idle(16'h0001, 16'h0000, 1'b1, 2'd1, 1);
        idle(16'h0002, 16'h0001, 1'b1, 2'd1, 2);
        idle(16'h0003, 16'h0002, 1'b1, 2'd1, 3);
        idle(16'h0004, 16'h0003, 1'b1, 2'd1, 4);
        idle(16'h0005, 16'h0004, 1'b1, 2'd1, 5);

        // Backward branch from 5 by -4 lands on 2, wrong-path word squashed.
        cyc(1'b0, 1'b1, 16'hFFFC, 1'b0, 26'h0, 1'b0, 1'b0, 16'h0002, 16'h0005, 1'b0, 2'd1, 5);
        idle(16'h0003, 16'h0002, 1'b1, 2'd1, 6);

        // Jump beats branch; upper jump_target bits ignored.
        cyc(1'b0, 1'b1, 16'h0005, 1'b1, 26'h3FF0010, 1'b0, 1'b0,
            16'h0010, 16'h0003, 1'b0, 2'd1, 6);
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 26'h0000006, 1'b0, 1'b0, 16'h0006, 16'h0010, 1'b0, 2'd1, 6);
        idle(16'h0007, 16'h0006, 1'b1, 2'd1, 7);
        idle(16'h0008, 16'h0007, 1'b1, 2'd1, 8);

        // Stall at 8 freezes everything, then stall+jump still redirects.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 1'b0, 16'h0008, 16'h0007, 1'b1, 2'd1, 8);
        end
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 26'h0000020, 1'b0, 1'b0, 16'h0020, 16'h0008, 1'b0, 2'd1, 8);
        idle(16'h0021, 16'h0020, 1'b1, 2'd1, 9);

        // pc wrap at 16'hFFFF and branch target wrap from 16'hFFF0.
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 26'h000FFFF, 1'b0, 1'b0, 16'hFFFF, 16'h0021, 1'b0, 2'd1, 9);
        idle(16'h0000, 16'hFFFF, 1'b1, 2'd1, 10);
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 26'h000FFF0, 1'b0, 1'b0, 16'hFFF0, 16'h0000, 1'b0, 2'd1, 10);
        cyc(1'b0, 1'b1, 16'h0020, 1'b0, 26'h0, 1'b0, 1'b0, 16'h0011, 16'hFFF0, 1'b0, 2'd1, 10);
        idle(16'h0012, 16'h0011, 1'b1, 2'd1, 11);

        // Halt at 4 (beats a simultaneous jump/branch), redirect inputs ignored while halted.
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 26'h0000004, 1'b0, 1'b0, 16'h0004, 16'h0012, 1'b0, 2'd1, 11);
        cyc(1'b0, 1'b1, 16'h0040, 1'b1, 26'h0000030, 1'b1, 1'b0,
            16'h0004, 16'h0012, 1'b0, 2'd2, 11);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 16'h0040, 1'b1, 26'h0000030, 1'b0, 1'b0,
                16'h0004, 16'h0012, 1'b0, 2'd2, 11);
        end
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 1'b1, 16'h0004, 16'h0012, 1'b0, 2'd2, 11);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 1'b1, 16'h0004, 16'h0012, 1'b0, 2'd1, 11);
        idle(16'h0005, 16'h0004, 1'b1, 2'd1, 12);
        idle(16'h0006, 16'h0005, 1'b1, 2'd1, 13);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 1'b0, 16'h0006, 16'h0005, 1'b0, 2'd2, 13);

        // Asynchronous reset during HALT, mid-cycle, then held across an edge.
        halt = 1'b0; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0; resume = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_reset(100);
        @(posedge clock);
        #2;
        chk_reset(101);
        @(negedge clock);
        reset = 1'b0;
        chk_reset(102);
        // Jump and stall presented during BOOT are ignored.
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 26'h0000040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd1, 0);
        idle(16'h0001, 16'h0000, 1'b1, 2'd1, 1);

        // Halt seen in BOOT goes straight to HALT.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd2, 0);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 2'd1, 0);
        idle(16'h0001, 16'h0000, 1'b1, 2'd1, 1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clock);
        end
        if (exp_q.size() > 0) begin
            n_tests++;
            n_failed++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_ADDR, default 16'h0000, the first instruction word address after reset.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port stall, input, 1, hold fetch (downstream not ready).
REQ-005 The block SHALL have port branch_taken, input, 1, redirect to pc_plus1+branch_offset.
REQ-006 The block SHALL have port branch_offset, input, 16, signed word offset.
REQ-007 The block SHALL have port jump, input, 1, redirect to jump_target[15:0].
REQ-008 The block SHALL have port jump_target, input, 26, jump field; only bits [15:0] used.
REQ-009 The block SHALL have ports halt and resume, input, 1 each, stop and restart fetching.
REQ-010 The block SHALL have port outAddy, output, 16, word address to instruction memory (memory registers it; data returns next cycle).
REQ-011 The block SHALL have port pc_plus1, output, 16, outAddy+1 mod 2^16.
REQ-012 The block SHALL have port ir_pc, output, 16, address of the word currently on the memory output.
REQ-013 The block SHALL have port fetch_valid, output, 1, memory output this cycle is a valid instruction.
REQ-014 The block SHALL have port state, output, 2, BOOT=0, RUN=1, HALT=2.
REQ-015 The block SHALL have port fetch_count, output, 32, number of valid fetches issued.

Function
REQ-016 The block SHALL drive outAddy directly from the pc register (no combinational path from inputs).
REQ-017 The FSM SHALL have states BOOT, RUN, and HALT: BOOT->RUN after one cycle unless halt (then HALT); RUN->HALT on halt; HALT->RUN on resume with halt low; resume with halt high stays in HALT.
REQ-018 In BOOT, pc SHALL hold RESET_ADDR and fetch_valid SHALL be driven 0.
REQ-019 Next-pc priority in RUN SHALL be: halt (hold) > jump > branch_taken > stall (hold) > pc+1.
REQ-020 The branch target SHALL be (pc+1)+sign_extend(branch_offset), truncated to 16 bits (wrap-around).
REQ-021 The jump target SHALL be jump_target[15:0].
REQ-022 At each edge in RUN with no halt, redirect or stall: ir_pc<=pc, fetch_valid<=1, fetch_count<=fetch_count+1.
REQ-023 On a redirect (jump or branch_taken, including during stall): ir_pc<=pc, fetch_valid<=0, and fetch_count unchanged; the wrong-path word is squashed.
REQ-024 On stall without redirect: pc, ir_pc, fetch_valid, and fetch_count SHALL hold.
REQ-025 On halt, or while in HALT: pc holds, fetch_valid<=0, fetch_count holds; resume restarts at the held pc.
REQ-026 pc 16'hFFFF SHALL increment to 16'h0000.
REQ-027 fetch_count SHALL wrap from 32'hFFFFFFFF to 0.
REQ-028 Inputs jump, branch_taken, and stall SHALL be ignored in BOOT and HALT.

Reset
REQ-029 While reset is high, regardless of clock: pc=RESET_ADDR, outAddy=RESET_ADDR, ir_pc=RESET_ADDR, fetch_valid=0, state=BOOT, fetch_count=0.
REQ-030 Reset asserted mid-operation SHALL abandon any stall, halt, or redirect; after deassertion, the block SHALL run BOOT then RUN from RESET_ADDR.

Verification
REQ-031 The bench SHALL cover: reset, release, 4 free-run cycles -> outAddy 0,0,1,2,3; fetch_valid 0,0,1,1,1; ir_pc 0,0,1,2; fetch_count=3.
REQ-032 The bench SHALL cover: at pc=5, branch_taken=1, branch_offset=16'hFFFC -> next outAddy=2; next fetch_valid=0; the following cycle fetch_valid=1 with ir_pc=2.
REQ-033 The bench SHALL cover: jump=1 and branch_taken=1 together, jump_target=26'h3FF0010 -> outAddy=16'h0010 (jump wins).
REQ-034 The bench SHALL cover: stall high for 3 cycles at pc=8 -> outAddy stays 8; fetch_valid, ir_pc, and fetch_count frozen; stall+jump -> redirect taken.
REQ-035 The bench SHALL cover: pc=16'hFFFF free-run -> outAddy=0; branch from 16'hFFF0 with offset 16'h0020 -> target 16'h0011.
REQ-036 The bench SHALL cover: halt at pc=4, 5 cycles, resume -> state 2, outAddy=4, fetch_valid=0; after resume, state=1 and fetching continues at 4; reset asserted during HALT -> all REQ-029 values.
